// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a multiplexed 7-segment bus, filters glitches,
// turns each stable segment pattern back into BCD and hands out whole frames
// over a valid/ready interface.
//
// Output FSM
//   state | meaning
//   EMPTY | no frame held, frame_valid low
//   FULL  | frame held on frame_bcd/frame_err, frame_valid high
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    overrun
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [7:0] CAP_AT   = 8'(STABLE_CYCLES - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   en_s1_q, en_s2_q;
    logic [NUM_DIGITS+6:0]   w_prev_q, w_now;
    logic [7:0]              cnt_q, cnt_d;
    logic                    dwell_ok, capture;
    logic [4:0]              dec_q5;
    logic [4*NUM_DIGITS-1:0] slot_bcd_q;
    logic [NUM_DIGITS-1:0]   slot_err_q;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_done;
    state_t                  state_q;
    logic [4*NUM_DIGITS-1:0] frame_bcd_q;
    logic [NUM_DIGITS-1:0]   frame_err_q;
    logic                    frame_valid_q, overrun_q;

    // Active-low a..g pattern to {err, nibble}; blank is legal and reads as F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'b0000001: return {1'b0, 4'h0};
            7'b1001111: return {1'b0, 4'h1};
            7'b0010010: return {1'b0, 4'h2};
            7'b0000110: return {1'b0, 4'h3};
            7'b1001100: return {1'b0, 4'h4};
            7'b0100100: return {1'b0, 4'h5};
            7'b1100000: return {1'b0, 4'h6};
            7'b0001111: return {1'b0, 4'h7};
            7'b0000000: return {1'b0, 4'h8};
            7'b0001100: return {1'b0, 4'h9};
            7'b1111111: return {1'b0, 4'hF};
            default:    return {1'b1, 4'hE};
        endcase
    endfunction

    // Two-flop synchronizers on the asynchronous display bus, plus last-sample register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
            en_s1_q  <= '0;
            en_s2_q  <= '0;
            w_prev_q <= '0;
            cnt_q    <= '0;
        end else begin
            seg_s1_q <= seg_in;
            seg_s2_q <= seg_s1_q;
            en_s1_q  <= digit_en;
            en_s2_q  <= en_s1_q;
            w_prev_q <= w_now;
            cnt_q    <= cnt_d;
        end
    end

    // Stability counter; capture fires once, on the step into STABLE_CYCLES-1.
    always_comb begin
        w_now    = {en_s2_q, seg_s2_q};
        dwell_ok = (w_now == w_prev_q) && $onehot(en_s2_q);
        if (!dwell_ok)
            cnt_d = '0;
        else if (cnt_q == STABLE_C)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 8'd1;
        capture    = dwell_ok && (cnt_d == CAP_AT);
        dec_q5     = decode_seg(seg_s2_q);
        frame_done = &seen_q;
        // A capture in the completing cycle starts the next frame.
        seen_d = frame_done ? '0 : seen_q;
        if (capture)
            seen_d = seen_d | en_s2_q;
    end

    // Slot registers and seen mask; a recapture overwrites the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_bcd_q <= '0;
            slot_err_q <= '0;
            seen_q     <= '0;
        end else begin
            seen_q <= seen_d;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && en_s2_q[i]) begin
                    slot_bcd_q[4*i +: 4] <= dec_q5[3:0];
                    slot_err_q[i]        <= dec_q5[4];
                end
            end
        end
    end

    // Output FSM with registered frame, valid and overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= EMPTY;
            frame_bcd_q   <= '0;
            frame_err_q   <= '0;
            frame_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (frame_done) begin
                        frame_bcd_q   <= slot_bcd_q;
                        frame_err_q   <= slot_err_q;
                        frame_valid_q <= 1'b1;
                        state_q       <= FULL;
                    end
                end
                FULL: begin
                    if (frame_ready) begin
                        if (frame_done) begin
                            frame_bcd_q <= slot_bcd_q;
                            frame_err_q <= slot_err_q;
                        end else begin
                            frame_valid_q <= 1'b0;
                            state_q       <= EMPTY;
                        end
                    end else if (frame_done) begin
                        overrun_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign frame_bcd   = frame_bcd_q;
    assign frame_err   = frame_err_q;
    assign frame_valid = frame_valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seg7_scan_decoder;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S6 = 7'b1100000, S7 = 7'b0001111, S8 = 7'b0000000,
                           S9 = 7'b0001100, SBL = 7'b1111111, SILL = 7'b0110000;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  err;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  digit_en;
    logic [15:0] frame_bcd;
    logic [3:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     ovr_cnt = 0;
    frame_t exp_q[$];
    frame_t mon_e;
    int     fv, nv, acc;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .digit_en    (digit_en),
        .frame_bcd   (frame_bcd),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one dwell of n cycles; returns first cycle (1-based) with valid high and count of valid cycles.
    // frame_ready is pulsed high for the single cycle following edge rdy_at.
    task automatic dwell(input logic [3:0] en, input logic [6:0] s, input int n,
                         input int rdy_at, output int first_v, output int n_v);
        digit_en = en;
        seg_in   = s;
        first_v  = 0;
        n_v      = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin
                n_v++;
                if (first_v == 0) first_v = c;
            end
            if (c == rdy_at) frame_ready = 1'b1;
            else if (c == rdy_at + 1) frame_ready = 1'b0;
        end
    endtask

    task automatic scan3(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        int f, v;
        dwell(4'b0001, a, 20, -5, f, v);
        dwell(4'b0010, b, 20, -5, f, v);
        dwell(4'b0100, c, 20, -5, f, v);
    endtask

    // Monitor: every accepted frame is compared with the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got bcd %h err %b, expected no frame", frame_bcd, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_bcd", {16'h0, frame_bcd}, {16'h0, mon_e.bcd});
                chk("frame_err", {28'h0, frame_err}, {28'h0, mon_e.err});
            end
        end
        if (overrun) ovr_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        seg_in      = SBL;
        digit_en    = 4'b0000;
        frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bcd",   {16'h0, frame_bcd}, 32'h0);
        chk("reset_err",   {28'h0, frame_err}, 32'h0);
        chk("reset_valid", {31'h0, frame_valid}, 32'h0);
        chk("reset_ovr",   {31'h0, overrun}, 32'h0);
        rst = 1'b0;

        // Normal scan, consumer always ready.
        exp_q.push_back('{16'h9543, 4'h0});
        scan3(S3, S4, S5);
        dwell(4'b1000, S9, 20, -5, fv, nv);
        chk("norm_valid_cycle", fv, 11);
        chk("norm_valid_len", nv, 1);

        // Blank, illegal, non-one-hot, then glitchy digit 0.
        exp_q.push_back('{16'h0EF8, 4'b0100});
        dwell(4'b0010, SBL, 20, -5, fv, nv);
        dwell(4'b0100, SILL, 20, -5, fv, nv);
        dwell(4'b1000, S0, 20, -5, fv, nv);
        dwell(4'b0011, S1, 30, -5, fv, nv);
        chk("nonhot_no_frame", nv, 0);
        dwell(4'b0001, S3, 5, -5, fv, acc);
        for (int k = 0; k < 6; k++) begin
            dwell(4'b0001, (k % 2 == 0) ? (S3 ^ 7'b0001000) : S3, 3, -5, fv, nv);
            acc += nv;
        end
        chk("glitch_no_frame", acc, 0);
        dwell(4'b0001, S8, 8, -5, fv, nv);
        chk("hold8_no_early_frame", nv, 0);
        dwell(4'b0000, SBL, 8, -5, fv, nv);
        chk("hold8_valid_cycle", fv, 3);
        chk("hold8_valid_len", nv, 1);

        // Backpressure: second frame dropped with overrun.
        frame_ready = 1'b0;
        exp_q.push_back('{16'h4321, 4'h0});
        scan3(S1, S2, S3);
        dwell(4'b1000, S4, 20, -5, fv, nv);
        chk("bp_valid_cycle", fv, 11);
        ovr_cnt = 0;
        scan3(S5, S6, S7);
        dwell(4'b1000, S8, 20, -5, fv, nv);
        chk("bp_overrun_pulses", ovr_cnt, 1);
        chk("bp_valid_held", {31'h0, frame_valid}, 32'h1);
        chk("bp_bcd_held", {16'h0, frame_bcd}, 32'h4321);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_valid_drop", {31'h0, frame_valid}, 32'h0);

        // Back-to-back: ready pulsed in the completing cycle.
        frame_ready = 1'b0;
        exp_q.push_back('{16'h2109, 4'h0});
        scan3(S9, S0, S1);
        dwell(4'b1000, S2, 20, -5, fv, nv);
        exp_q.push_back('{16'h6543, 4'h0});
        ovr_cnt = 0;
        scan3(S3, S4, S5);
        dwell(4'b1000, S6, 20, 10, fv, nv);
        chk("b2b_valid_stays", nv, 20);
        chk("b2b_new_bcd", {16'h0, frame_bcd}, 32'h6543);
        chk("b2b_no_overrun", ovr_cnt, 0);
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_valid_drop", {31'h0, frame_valid}, 32'h0);

        // Reset with a pending frame and three digits captured.
        frame_ready = 1'b0;
        scan3(S7, S7, S7);
        dwell(4'b1000, S7, 20, -5, fv, nv);
        chk("pre_rst_valid", {31'h0, frame_valid}, 32'h1);
        scan3(S1, S2, S3);
        rst = 1'b1;
        #2;
        chk("rst_async_bcd",   {16'h0, frame_bcd}, 32'h0);
        chk("rst_async_err",   {28'h0, frame_err}, 32'h0);
        chk("rst_async_valid", {31'h0, frame_valid}, 32'h0);
        chk("rst_async_ovr",   {31'h0, overrun}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_held_valid", {31'h0, frame_valid}, 32'h0);
        rst = 1'b0;
        frame_ready = 1'b1;
        dwell(4'b1000, S4, 30, -5, fv, nv);
        chk("rst_partial_no_frame", nv, 0);
        exp_q.push_back('{16'h421E, 4'b0001});
        dwell(4'b0001, SILL, 20, -5, fv, nv);
        acc = nv;
        dwell(4'b0010, S1, 20, -5, fv, nv);
        acc += nv;
        chk("rst_rescan_no_early", acc, 0);
        dwell(4'b0100, S2, 20, -5, fv, nv);
        chk("rst_rescan_valid_cycle", fv, 11);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart to the BCD-to-7-segment decoder. Monitors a multiplexed 7-segment display bus, made of one shared segment vector plus one-hot digit enables, driven by an external or legacy controller.
- Filters glitches and turns each stable segment pattern back into a BCD digit.
- Assembles one frame covering all digits and presents it on a valid/ready interface for logging or self-check logic.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 8, consecutive identical synchronized samples required before a capture (2..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment bus, bit6=a .. bit0=g, active-low (0 = lit). This is the same encoding the decoder drives on segments_anode. Asynchronous to clk.
- digit_en  input  NUM_DIGITS  digit enables, active-high, expected one-hot. Asynchronous to clk.
- frame_bcd  output  4*NUM_DIGITS  decoded frame; digit i occupies bits [4i+3:4i].
- frame_err  output  NUM_DIGITS  per-digit flag: captured pattern was not a legal code.
- frame_valid  output  1  frame_bcd/frame_err hold a frame.
- frame_ready  input  1  consumer accepts the frame.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.

Behaviour:
- Reset (async assert; state held while rst=1):
  - frame_bcd=0, frame_err=0, frame_valid=0, overrun=0.
  - Sync flops and previous-sample register = 0.
  - Stability counter = 0.
  - Slot registers = 0; seen mask = 0.
- Synchronizer:
  - seg_in and digit_en each pass through 2 flops.
  - The synchronized word is W = {digit_en_s, seg_s}.
- Stability counter:
  - If W == previous W and digit_en_s is exactly one-hot, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise (W changed, zero enables, or more than one enable) the counter resets to 0.
- Capture:
  - Occurs in the cycle the counter reaches STABLE_CYCLES-1, i.e. after W has been held STABLE_CYCLES cycles.
  - Slot i (the enabled digit) is written with the decoded nibble and error bit, and seen[i] is set.
  - Exactly one capture per dwell; no further capture until W changes.
  - Latency from a pin change to slot update: 2 + STABLE_CYCLES cycles.
- Decode table (seg_in, active-low, a..g):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4
  - 0100100->5, 1100000->6, 0001111->7, 0000000->8, 0001100->9
  - 1111111 (blank) -> 4'hF, err=0.
  - Any other pattern -> 4'hE, err=1.
- Recapture within a frame: a digit captured again before the frame completes overwrites its slot (latest wins); seen[i] stays set.
- Frame assembly:
  - When seen becomes all-ones, the frame is complete. The transfer attempt happens the cycle after the final capture.
  - Output FSM, state EMPTY: load slots into frame_bcd/frame_err, set frame_valid, clear seen. Go to FULL.
  - Output FSM, state FULL: frame_valid=1; frame_bcd/frame_err held stable. frame_ready=1 completes the handshake.
  - FULL with handshake and no new frame ready: go to EMPTY, frame_valid=0 next cycle.
  - FULL with handshake in the same cycle a new frame completes: load the new frame and stay FULL (back-to-back, no bubble).
  - FULL without handshake when a new frame completes: the new frame is discarded, seen is cleared, overrun pulses for 1 cycle, and the output is unchanged.
- Capture concurrent with frame completion: a capture in the same cycle seen is cleared belongs to the next frame, so seen is set only for that digit.
- frame_ready while EMPTY is ignored.
- Reset mid-frame: partial slots and any pending output frame are discarded; no valid is produced.

Test Plan:
- NUM_DIGITS=4, STABLE_CYCLES=8.
- Normal scan: drive digits 0..3 with 0000110, 1001100, 0100100, 0001100, 20 cycles each; frame_ready=1. Expect frame_bcd=16'h9543, frame_err=0, frame_valid high 1 cycle after the digit-3 capture, for 1 cycle.
- Glitch filter: digit 0 held 5 cycles, then toggles seg bit3 every 3 cycles. Expect no capture and seen[0] stays 0. Then hold 0000000 for 8 cycles. Expect the slot to become 8 exactly 10 cycles after the last pin change.
- Illegal, blank and non-one-hot enables: digit 1 = 1111111 gives nibble F with err 0. Digit 2 = 0110000 gives nibble E with frame_err[2]=1. digit_en=4'b0011 held 30 cycles gives no capture.
- Backpressure/overrun: frame_ready=0, complete two full scans. Expect the first frame held unchanged, a single-cycle overrun pulse at the second completion, and frame_valid still 1. Raise frame_ready: frame_valid drops next cycle.
- Back-to-back: frame_ready pulsed in the exact cycle the next frame completes. Expect frame_valid to stay 1, the new data to appear next cycle, and overrun=0.
- Reset mid-operation: assert rst after 3 of 4 digits captured, release, then scan only digit 3. Expect no frame_valid until all 4 digits have been rescanned, and all outputs 0 during reset.
